// File: rtl/serial_rx8b_if.sv
// rtl/serial_rx8b_if.sv - serial line, byte output and status signals of serial_rx8b
interface serial_rx8b_if;
  logic       s_in;
  logic       bit_en;
  logic       ack;
  logic [7:0] Q;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    input  s_in, bit_en, ack,
    output Q, valid, busy, frame_err, overrun
  );

  modport slave (
    output s_in, bit_en, ack,
    input  Q, valid, busy, frame_err, overrun
  );
endinterface

// File: rtl/serial_rx8b.sv
// rtl/serial_rx8b.sv - strobed serial byte receiver (start, 8 data, stop) with valid/ack hold-off
module serial_rx8b #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_rx8b_if.master bus
);

  typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;

  state_t     state, state_nxt;
  logic [2:0] cnt, cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic       stop_good, stop_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 3'd0;
      shreg <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      shreg <= shreg_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    shreg_nxt = shreg;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    if (bus.bit_en) begin
      case (state)
        IDLE: begin
          if (!bus.s_in) begin
            state_nxt = DATA;
            cnt_nxt   = 3'd0;
          end
        end
        DATA: begin
          shreg_nxt = MSB_FIRST ? {shreg[6:0], bus.s_in} : {bus.s_in, shreg[7:1]};
          // counter wraps from 7 back to 0 on the eighth data bit
          cnt_nxt = cnt + 3'd1;
          if (cnt == 3'd7) begin
            state_nxt = STOP;
          end
        end
        STOP: begin
          stop_good = bus.s_in;
          stop_bad  = !bus.s_in;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.Q         <= 8'h00;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= stop_bad;
      if (stop_good) begin
        bus.Q       <= shreg;
        bus.valid   <= 1'b1;
        // a simultaneous ack consumes the old byte, so nothing is lost
        bus.overrun <= bus.valid && !bus.ack;
      end else if (bus.ack && bus.valid) begin
        bus.valid   <= 1'b0;
        bus.overrun <= 1'b0;
      end
    end
  end

  assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_serial_rx8b.sv
// tb/tb_serial_rx8b.sv - scoreboard bench for serial_rx8b, both bit orders side by side
module tb_serial_rx8b;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_in = 1'b1;
  logic bit_en = 1'b0;
  logic ack = 1'b0;
  logic ack_on_stop = 1'b0;

  always #5 clk = ~clk;

  serial_rx8b_if m_if ();
  serial_rx8b_if l_if ();

  assign m_if.s_in   = s_in;
  assign m_if.bit_en = bit_en;
  assign m_if.ack    = ack;
  assign l_if.s_in   = s_in;
  assign l_if.bit_en = bit_en;
  assign l_if.ack    = ack;

  serial_rx8b #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(m_if.master));
  serial_rx8b #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(l_if.master));

  typedef struct packed {
    logic       ferr;
    logic [7:0] q;
    logic       valid;
    logic       ovr;
  } exp_t;

  exp_t q_m[$];
  exp_t q_l[$];
  int   checks = 0;
  int   errors = 0;
  int   strobes_busy;
  logic pb_m = 1'b0;
  logic pb_l = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int period, input logic a);
    for (int i = 1; i < period; i++) begin
      bit_en = 1'b0;
      s_in   = ~s_in;
      tick();
    end
    if (m_if.busy) strobes_busy++;
    bit_en = 1'b1;
    s_in   = b;
    ack    = a;
    tick();
    bit_en = 1'b0;
    ack    = 1'b0;
    s_in   = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop, input int period);
    strobes_busy = 0;
    send_bit(1'b0, period, 1'b0);
    for (int i = 7; i >= 0; i--) send_bit(data[i], period, 1'b0);
    send_bit(stop, period, ack_on_stop);
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_m_q"},    32'(m_if.Q), 32'h0);
    chk({tag, "_m_valid"}, 32'(m_if.valid), 32'h0);
    chk({tag, "_m_busy"},  32'(m_if.busy), 32'h0);
    chk({tag, "_m_ferr"},  32'(m_if.frame_err), 32'h0);
    chk({tag, "_m_ovr"},   32'(m_if.overrun), 32'h0);
    chk({tag, "_l_q"},    32'(l_if.Q), 32'h0);
    chk({tag, "_l_valid"}, 32'(l_if.valid), 32'h0);
    chk({tag, "_l_busy"},  32'(l_if.busy), 32'h0);
  endtask

  task automatic push(input exp_t em, input exp_t el);
    q_m.push_back(em);
    q_l.push_back(el);
  endtask

  // frame end is seen as busy falling outside reset
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pb_m && !m_if.busy) begin
      if (q_m.size() == 0) begin
        chk("m_unexpected_frame", 32'(q_m.size()), 32'd1);
      end else begin
        e = q_m.pop_front();
        chk("m_frame_err", 32'(m_if.frame_err), 32'(e.ferr));
        chk("m_q",         32'(m_if.Q), 32'(e.q));
        chk("m_valid",     32'(m_if.valid), 32'(e.valid));
        chk("m_overrun",   32'(m_if.overrun), 32'(e.ovr));
      end
    end
    pb_m = m_if.busy;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && pb_l && !l_if.busy) begin
      if (q_l.size() == 0) begin
        chk("l_unexpected_frame", 32'(q_l.size()), 32'd1);
      end else begin
        e = q_l.pop_front();
        chk("l_frame_err", 32'(l_if.frame_err), 32'(e.ferr));
        chk("l_q",         32'(l_if.Q), 32'(e.q));
        chk("l_valid",     32'(l_if.valid), 32'(e.valid));
        chk("l_overrun",   32'(l_if.overrun), 32'(e.ovr));
      end
    end
    pb_l = l_if.busy;
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    zero_chk("reset");
    rst_n = 1'b1;
    tick();

    // 0x55 on the line: MSB-first gives 55, LSB-first gives AA
    push('{1'b0, 8'h55, 1'b1, 1'b0}, '{1'b0, 8'hAA, 1'b1, 1'b0});
    send_frame(8'h55, 1'b1, 1);
    chk("busy_strobes_p1", 32'(strobes_busy), 32'd9);
    ack_pulse();
    chk("ack_clr_m_valid", 32'(m_if.valid), 32'h0);
    chk("ack_clr_l_valid", 32'(l_if.valid), 32'h0);

    // sparse strobes with the line toggling in between
    push('{1'b0, 8'hB2, 1'b1, 1'b0}, '{1'b0, 8'h4D, 1'b1, 1'b0});
    send_frame(8'hB2, 1'b1, 4);
    chk("busy_strobes_p4", 32'(strobes_busy), 32'd9);
    ack_pulse();

    // bad stop bit keeps previous byte and valid
    push('{1'b1, 8'hB2, 1'b0, 1'b0}, '{1'b1, 8'h4D, 1'b0, 1'b0});
    send_frame(8'hF0, 1'b0, 1);
    chk("ferr_high", 32'(m_if.frame_err), 32'h1);
    tick();
    chk("ferr_one_cycle", 32'(m_if.frame_err), 32'h0);
    chk("idle_after_err", 32'(m_if.busy), 32'h0);

    // overrun
    push('{1'b0, 8'h12, 1'b1, 1'b0}, '{1'b0, 8'h48, 1'b1, 1'b0});
    send_frame(8'h12, 1'b1, 1);
    push('{1'b0, 8'h34, 1'b1, 1'b1}, '{1'b0, 8'h2C, 1'b1, 1'b1});
    send_frame(8'h34, 1'b1, 1);

    // good stop together with ack clears overrun, keeps valid
    ack_on_stop = 1'b1;
    push('{1'b0, 8'h3C, 1'b1, 1'b0}, '{1'b0, 8'h3C, 1'b1, 1'b0});
    send_frame(8'h3C, 1'b1, 1);
    ack_on_stop = 1'b0;
    ack_pulse();
    chk("final_ack_valid", 32'(m_if.valid), 32'h0);
    chk("final_ack_ovr",   32'(m_if.overrun), 32'h0);
    chk("q_held_after_ack", 32'(m_if.Q), 32'h3C);

    // reset mid-frame after four data bits
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b0, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    send_bit(1'b1, 1, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    zero_chk("midreset");
    rst_n = 1'b1;
    tick();
    push('{1'b0, 8'hC3, 1'b1, 1'b0}, '{1'b0, 8'hC3, 1'b1, 1'b0});
    send_frame(8'hC3, 1'b1, 1);

    repeat (3) tick();
    chk("m_queue_drained", 32'(q_m.size()), 32'd0);
    chk("l_queue_drained", 32'(q_l.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_rx8b.md
SERIAL_RX8B -- requirements
Module: serial_rx8b

Interface
REQ-001 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = first data bit received lands in Q[7] and 0 = first data bit lands in Q[0].
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port s_in, input, 1 bit: serial line; idles high.
REQ-005 The block SHALL have port bit_en, input, 1 bit: bit strobe; s_in is sampled only on edges where bit_en=1.
REQ-006 The block SHALL have port ack, input, 1 bit: consumer acknowledge of the byte on Q.
REQ-007 The block SHALL have port Q, output, 8 bits: last completed byte.
REQ-008 The block SHALL have port valid, output, 1 bit: Q holds an unacknowledged byte.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-011 The block SHALL have port overrun, output, 1 bit: sticky flag; a byte was overwritten before ack.

Function
REQ-012 Frame format SHALL be start bit 0, then 8 data bits, then stop bit 1, with one bit per bit_en strobe.
REQ-013 The FSM SHALL have states IDLE, DATA and STOP; on edges with bit_en=0, state, bit counter and shift register SHALL hold.
REQ-014 In IDLE, an edge with bit_en=1 and s_in=0 SHALL move to DATA and clear the 3-bit counter; s_in=1 SHALL stay in IDLE.
REQ-015 In DATA, each edge with bit_en=1 SHALL shift s_in into the internal 8-bit shift register and increment the counter.
REQ-016 Shift direction: MSB_FIRST=1 SHALL shift left with s_in into bit 0; MSB_FIRST=0 SHALL shift right with s_in into bit 7.
REQ-017 DATA SHALL move to STOP on the strobe that samples the 8th data bit (counter=7); the counter SHALL wrap to 0.
REQ-018 STOP with bit_en=1 and s_in=1 SHALL copy the shift register to Q, set valid=1 and return to IDLE.
REQ-019 STOP with bit_en=1 and s_in=0 SHALL leave Q and valid unchanged, pulse frame_err for exactly one cycle and return to IDLE.
REQ-020 Latency: Q, valid and frame_err SHALL be visible in the cycle after the edge that samples the stop bit.
REQ-021 ack=1 with valid=1 SHALL clear valid and overrun on that edge; ack=1 with valid=0 SHALL have no effect.
REQ-022 A good stop bit arriving while valid=1 and ack=0 SHALL load the new byte into Q, keep valid=1 and set overrun=1.
REQ-023 A good stop bit coinciding with ack=1 SHALL load Q and keep valid=1; overrun SHALL be cleared, not set.
REQ-024 busy SHALL be 1 exactly when the state is DATA or STOP.
REQ-025 Q SHALL change only on a good stop bit or on reset.

Reset
REQ-026 rst_n=0 at an edge SHALL force state=IDLE, counter=0, shift register=0, Q=8'h00, valid=0, busy=0, frame_err=0 and overrun=0, overriding all other inputs.
REQ-027 Reset asserted mid-frame SHALL abandon the partial byte; the next frame after release SHALL be received normally.

Verification
REQ-028 Bench case: with MSB_FIRST=1 and bit_en=1 every cycle, send 0,0,1,0,1,0,1,0,1,1 -> Q=8'h55 and valid=1 one cycle after the stop bit; frame_err=0 and overrun=0.
REQ-029 Bench case: repeat REQ-028 with MSB_FIRST=0 -> Q=8'hAA.
REQ-030 Bench case: bit_en=1 only every 4th cycle while s_in toggles between strobes -> byte decoded from strobed samples only, and busy stays high for 9 strobes.
REQ-031 Bench case: send 8'hF0 with stop bit 0 -> frame_err high exactly one cycle, Q keeps its prior value, valid unchanged, block back in IDLE.
REQ-032 Bench case: send 8'h12 without ack, then 8'h34 -> Q=8'h34, valid=1, overrun=1; a following ack clears both valid and overrun.
REQ-033 Bench case: assert rst_n=0 after 4 data bits, release it, then send 8'hC3 -> all outputs 0 during reset, then Q=8'hC3 and valid=1.
